led_seq_ctrl: RTL and testbench

- Controller that sequences the 6-bit one-hot colour rotation register feeding the RGB colour decoder.
- Replaces the free-running blink counter with commanded run, pause, stop, single-step and pattern-load.
- Adds selectable rotation direction and a revolution-count auto-stop.
- Output pattern drives the colour decoder directly; tick/wrap/done pulses are available to other logic.

---
 rtl/led_seq_if.sv | 28 ++
 rtl/led_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/led_seq_if.sv
// Command/status bundle between a sequencer master and the led_seq_ctrl slave.
interface led_seq_if #(
  parameter int N = 6
);
  logic         start;
  logic         pause;
  logic         stop;
  logic         step;
  logic         load;
  logic [N-1:0] load_d;
  logic         dir;
  logic [7:0]   reps;
  logic [N-1:0] pattern;
  logic         tick;
  logic         wrap;
  logic         done;
  logic         running;

  modport master (
    output start, pause, stop, step, load, load_d, dir, reps,
    input  pattern, tick, wrap, done, running
  );

  modport slave (
    input  start, pause, stop, step, load, load_d, dir, reps,
    output pattern, tick, wrap, done, running
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// Run/pause/stop/step/load sequencer for the one-hot colour rotation register.
// Optional bounce sweep enabled by defining LED_SEQ_BOUNCE_EN.
module led_seq_ctrl #(
  parameter int N        = 6,
  parameter int TICK_MAX = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  led_seq_if.slave    bus
);

  localparam int CW = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
  localparam int PW = (N > 2) ? $clog2(N) : 1;
`ifdef LED_SEQ_BOUNCE_EN
  localparam int WRAP_CNT = N - 1;
`else
  localparam int WRAP_CNT = N;
`endif
  localparam logic [N-1:0] PAT_TOP = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pattern_q, pattern_d;
  logic [CW-1:0]  tcnt_q, tcnt_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic [7:0]     rev_q, rev_d;
  logic [7:0]     reps_q, reps_d;
  logic           tick_q, tick_d;
  logic           wrap_q, wrap_d;
  logic           done_q, done_d;
  logic           running_q;

  logic           adv_dir_s;
  logic           run_cnt_s;
  logic           tc_s;
  logic           last_pos_s;
  logic [7:0]     rev_inc_s;

  function automatic logic [N-1:0] rot_f(input logic [N-1:0] p, input logic right);
    if (right) begin
      return {p[0], p[N-1:1]};
    end else begin
      return {p[N-2:0], p[N-1]};
    end
  endfunction

`ifdef LED_SEQ_BOUNCE_EN
  logic edir_q, edir_d;

  // Effective direction: seeded from dir on fresh start or load, flipped at every wrap.
  always_comb begin
    edir_d = edir_q;
    if (bus.load) begin
      edir_d = bus.dir;
    end else if (!bus.stop && !bus.pause && bus.start && (state_q == ST_IDLE)) begin
      edir_d = bus.dir;
    end else if (run_cnt_s && tc_s && last_pos_s) begin
      edir_d = ~edir_q;
    end else begin
      edir_d = edir_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edir_q <= 1'b0;
    end else begin
      edir_q <= edir_d;
    end
  end

  assign adv_dir_s = edir_q;
`else
  assign adv_dir_s = bus.dir;
`endif

  // The RUN counter only moves in cycles where no state-changing command wins.
  assign run_cnt_s  = (state_q == ST_RUN) && !bus.load && !bus.stop && !bus.pause;
  assign tc_s       = (tcnt_q == CW'(TICK_MAX - 1));
  assign last_pos_s = (pos_q == PW'(WRAP_CNT - 1));
  assign rev_inc_s  = rev_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    tcnt_d    = tcnt_q;
    pos_d     = pos_q;
    rev_d     = rev_q;
    reps_d    = reps_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    done_d    = 1'b0;

    if (bus.load) begin
      pattern_d = (bus.load_d == '0) ? PAT_TOP : bus.load_d;
      tcnt_d    = '0;
      pos_d     = '0;
    end else if (bus.stop) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end else begin
        state_d = state_q;
      end
    end else if (bus.pause) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end else begin
        state_d = state_q;
      end
    end else if (bus.start) begin
      case (state_q)
        ST_IDLE: begin
          reps_d  = bus.reps;
          rev_d   = 8'd0;
          tcnt_d  = '0;
          state_d = ST_RUN;
        end
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end else if (bus.step) begin
      if (state_q != ST_RUN) begin
        pattern_d = rot_f(pattern_q, adv_dir_s);
        tick_d    = 1'b1;
      end else begin
        tick_d    = 1'b0;
      end
    end else begin
      state_d = state_q;
    end

    if (run_cnt_s) begin
      if (tc_s) begin
        tcnt_d    = '0;
        pattern_d = rot_f(pattern_q, adv_dir_s);
        tick_d    = 1'b1;
        if (last_pos_s) begin
          pos_d  = '0;
          wrap_d = 1'b1;
          rev_d  = rev_inc_s;
          if ((reps_q != 8'd0) && (rev_inc_s == reps_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            done_d  = 1'b0;
          end
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end else begin
        tcnt_d = tcnt_q + CW'(1);
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // running mirrors the state register one clock later, so it stays high through the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pattern_q <= PAT_TOP;
      tcnt_q    <= '0;
      pos_q     <= '0;
      rev_q     <= 8'd0;
      reps_q    <= 8'd0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      tcnt_q    <= tcnt_d;
      pos_q     <= pos_d;
      rev_q     <= rev_d;
      reps_q    <= reps_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      running_q <= (state_q == ST_RUN);
    end
  end

  assign bus.pattern = pattern_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.done    = done_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: directed scenarios then random commands vs a cycle model.
module tb_led_seq_ctrl;
  localparam int N  = 6;
  localparam int TM = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;

  logic clk = 1'b0;
  logic reset;

  led_seq_if #(.N(N)) bus ();

  led_seq_ctrl #(.N(N), .TICK_MAX(TM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] pat;
    logic         tick;
    logic         wrap;
    logic         done;
    logic         running;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit stop_mon = 1'b0;

  // Reference model state: cycles elapsed since last advance, advances this revolution.
  int m_state, m_pat, m_cnt, m_adv, m_rev, m_reps;

  function automatic int rot(int p, bit right);
    if (right) return (p >> 1) | ((p & 1) << (N - 1));
    else       return ((p << 1) | (p >> (N - 1))) & ((1 << N) - 1);
  endfunction

  function automatic void model_cycle();
    exp_t e;
    int old = m_state;
    int cmd;
    e.tick = 1'b0; e.wrap = 1'b0; e.done = 1'b0;
    e.running = (!reset && old == S_RUN);
    if (reset) begin
      m_pat = 1 << (N - 1); m_state = S_IDLE;
      m_cnt = 0; m_adv = 0; m_rev = 0; m_reps = 0;
    end else begin
      cmd = bus.load ? 1 : bus.stop ? 2 : bus.pause ? 3 : bus.start ? 4 : bus.step ? 5 : 0;
      case (cmd)
        1: begin
          m_pat = (bus.load_d == 0) ? (1 << (N - 1)) : int'(bus.load_d);
          m_cnt = 0; m_adv = 0;
        end
        2: if (old != S_IDLE) begin m_state = S_IDLE; m_cnt = 0; end
        3: if (old == S_RUN) m_state = S_PAUSE;
        4: begin
          if (old == S_IDLE) begin
            m_reps = int'(bus.reps); m_rev = 0; m_cnt = 0; m_state = S_RUN;
          end else if (old == S_PAUSE) begin
            m_state = S_RUN;
          end
        end
        5: if (old != S_RUN) begin m_pat = rot(m_pat, bus.dir); e.tick = 1'b1; end
        default: ;
      endcase
      if (old == S_RUN && (cmd == 0 || cmd >= 4)) begin
        m_cnt++;
        if (m_cnt == TM) begin
          m_cnt = 0;
          m_pat = rot(m_pat, bus.dir);
          e.tick = 1'b1;
          m_adv++;
          if (m_adv == N) begin
            m_adv = 0; e.wrap = 1'b1; m_rev++;
            if (m_reps != 0 && m_rev == m_reps) begin
              e.done = 1'b1; m_state = S_IDLE;
            end
          end
        end
      end
    end
    e.pat = m_pat[N-1:0];
    exp_q.push_back(e);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
    end
  endtask

  // Monitor: pops one expected record per clock and compares every output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (stop_mon) break;
      cyc_n++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cyc_n);
      end else begin
        e = exp_q.pop_front();
        chk("pattern", 32'(bus.pattern), 32'(e.pat));
        chk("tick",    32'(bus.tick),    32'(e.tick));
        chk("wrap",    32'(bus.wrap),    32'(e.wrap));
        chk("done",    32'(bus.done),    32'(e.done));
        chk("running", 32'(bus.running), 32'(e.running));
      end
    end
  end

  task automatic clr();
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    bus.step = 1'b0; bus.load = 1'b0;
  endtask

  task automatic cyc();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int r;
    m_state = S_IDLE; m_pat = 1 << (N - 1);
    m_cnt = 0; m_adv = 0; m_rev = 0; m_reps = 0;
    clr();
    bus.dir = 1'b0; bus.reps = 8'd0; bus.load_d = 6'd0;

    // Reset held two cycles with commands toggling underneath
    reset = 1'b1; bus.start = 1'b1; bus.load = 1'b1; bus.load_d = 6'b000101;
    cyc();
    bus.start = 1'b0; bus.step = 1'b1; bus.dir = 1'b1;
    cyc();
    reset = 1'b0; clr(); bus.dir = 1'b0;
    run(2);

    // One revolution with auto-stop
    bus.reps = 8'd1; bus.start = 1'b1; cyc(); clr();
    run(28);

    // Pause after two counts, hold, resume
    bus.reps = 8'd0; bus.start = 1'b1; cyc(); clr();
    run(2);
    bus.pause = 1'b1; cyc(); clr();
    run(10);
    bus.start = 1'b1; cyc(); clr();
    run(6);

    // Load during RUN, then load of zero
    run(1);
    bus.load = 1'b1; bus.load_d = 6'b000100; cyc(); clr();
    run(5);
    bus.load = 1'b1; bus.load_d = 6'b000000; cyc(); clr();
    run(2);

    // Step in PAUSE with dir=1, then step ignored in RUN
    bus.pause = 1'b1; cyc(); clr();
    bus.load = 1'b1; bus.load_d = 6'b000100; cyc(); clr();
    bus.dir = 1'b1; bus.step = 1'b1; cyc(); clr();
    run(2);
    bus.start = 1'b1; cyc(); clr();
    bus.step = 1'b1; run(3); clr();

    // start+stop together, then reset mid-count
    bus.start = 1'b1; bus.stop = 1'b1; cyc(); clr();
    run(3);
    bus.start = 1'b1; cyc(); clr();
    run(2);
    reset = 1'b1; cyc(); reset = 1'b0;
    run(3);

    // Random command mix
    for (int i = 0; i < 2000; i++) begin
      clr();
      r = $urandom_range(0, 99);
      if (r < 3) begin
        bus.load = 1'b1;
        bus.load_d = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      end else if (r < 5)  bus.stop = 1'b1;
      else if (r < 8)  bus.pause = 1'b1;
      else if (r < 14) bus.start = 1'b1;
      else if (r < 20) bus.step = 1'b1;
      else if (r < 23) begin
        bus.start = 1'($urandom); bus.stop = 1'($urandom);
        bus.pause = 1'($urandom); bus.step = 1'($urandom);
      end
      if ($urandom_range(0, 19) == 0) bus.dir = ~bus.dir;
      if ($urandom_range(0, 9) == 0) bus.reps = 8'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0; clr();
    run(2);

    @(negedge clk);
    #1;
    stop_mon = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
